// File: rtl/bft_pkg.sv
// Shared encodings and bus helpers for the binary fat-tree switch family.
// Buses are {valid, dest, payload}; helpers take the bus zero-extended to MAX_BUS bits.
package bft_pkg;

  typedef enum logic [1:0] {
    VOID  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    UP    = 2'd3
  } dir_t;

  localparam int MAX_AW  = 32;
  localparam int MAX_BUS = 256;

  function automatic logic bus_valid(input logic [MAX_BUS-1:0] bus, input int p_sz);
    return bus[p_sz-1];
  endfunction

  function automatic logic [MAX_AW-1:0] bus_dest(input logic [MAX_BUS-1:0] bus,
                                                 input int payload_sz, input int aw);
    logic [MAX_BUS-1:0] shifted;
    logic [MAX_AW-1:0]  mask;
    shifted = bus >> payload_sz;
    mask    = '1;
    mask    = mask >> (MAX_AW - aw);
    return shifted[MAX_AW-1:0] & mask;
  endfunction

  // The root splits on the top dest bit; inner switches keep only their own subtree.
  function automatic dir_t route(input logic [MAX_AW-1:0] dest, input int aw,
                                 input int level, input int addr);
    logic [MAX_AW-1:0] prefix;
    logic [MAX_AW-1:0] want;
    if (level == 0) return dest[aw-1] ? RIGHT : LEFT;
    prefix = dest >> (aw - level);
    want   = MAX_AW'(addr);
    if (prefix == want) return dest[aw-1-level] ? RIGHT : LEFT;
    return UP;
  endfunction

endpackage

// File: rtl/bft_fifo.sv
// Synchronous FIFO with occupancy count; the head word is presented combinationally on rd_data.
// Pointers wrap naturally because DEPTH is a power of two.
module bft_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/t_switch_buf.sv
// Buffered 3-port fat-tree switch: one FIFO per input, round-robin arbitration per output,
// one register stage per output. Port index 0 = L, 1 = R, 2 = U (absent at the root).
module t_switch_buf
  import bft_pkg::*;
#(
  parameter int  NUM_LEAVES = 256,
  parameter int  PAYLOAD_SZ = 43,
  parameter int  LEVEL      = 7,
  parameter int  ADDR       = 0,
  parameter int  FIFO_DEPTH = 4,
  localparam int AW         = $clog2(NUM_LEAVES),
  localparam int P_SZ       = 1 + AW + PAYLOAD_SZ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [P_SZ-1:0] l_bus_i,
  input  logic [P_SZ-1:0] r_bus_i,
  input  logic [P_SZ-1:0] u_bus_i,
  output logic            l_ready_o,
  output logic            r_ready_o,
  output logic            u_ready_o,
  output logic [P_SZ-1:0] l_bus_o,
  output logic [P_SZ-1:0] r_bus_o,
  output logic [P_SZ-1:0] u_bus_o,
  input  logic            l_ready_i,
  input  logic            r_ready_i,
  input  logic            u_ready_i
);

  localparam bit            HAS_UP    = (LEVEL != 0);
  localparam int            NIN       = HAS_UP ? 3 : 2;
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]    PORT_EN   = {HAS_UP, 2'b11};

  logic [P_SZ-1:0] bus_in  [3];
  logic [P_SZ-1:0] head    [3];
  logic [P_SZ-1:0] out_q   [3];
  logic [CW-1:0]   count   [3];
  logic            full    [3];
  logic            empty   [3];
  dir_t            head_dir[3];
  logic [1:0]      gnt_idx [3];
  logic [1:0]      rr_ptr  [3];
  logic [2:0]      wr_en;
  logic [2:0]      pop;
  logic [2:0]      rdy;
  logic [2:0]      ready_in;
  logic [2:0]      can_load;
  logic [2:0]      gnt_any;
  logic            rst_q;

  assign bus_in   = '{l_bus_i, r_bus_i, u_bus_i};
  assign ready_in = {u_ready_i, r_ready_i, l_ready_i};

  function automatic logic [1:0] rr_pick(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NIN) s = s - NIN;
    return 2'(s);
  endfunction

  function automatic dir_t out_dir(input int o);
    case (o)
      0:       return LEFT;
      1:       return RIGHT;
      default: return UP;
    endcase
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_in
    bft_fifo #(
      .W    (P_SZ),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en[i]),
      .wr_data(bus_in[i]),
      .rd_en  (pop[i]),
      .rd_data(head[i]),
      .full   (full[i]),
      .empty  (empty[i]),
      .count  (count[i])
    );
  end

  // Ready depends only on the count and the registered reset flag, never on inputs.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdy[i]      = PORT_EN[i] && !rst_q && (count[i] != DEPTH_CNT);
      wr_en[i]    = PORT_EN[i] && !rst_q && !full[i] &&
                    bus_valid(MAX_BUS'(bus_in[i]), P_SZ);
      head_dir[i] = VOID;
      if (PORT_EN[i] && !empty[i])
        head_dir[i] = route(bus_dest(MAX_BUS'(head[i]), PAYLOAD_SZ, AW), AW, LEVEL, ADDR);
    end
  end

  // Scan from the pointer downward so the candidate closest to the pointer wins.
  always_comb begin
    pop = '0;
    for (int o = 0; o < 3; o++) begin
      can_load[o] = PORT_EN[o] && (!out_q[o][P_SZ-1] || ready_in[o]);
      gnt_any[o]  = 1'b0;
      gnt_idx[o]  = 2'd0;
      for (int k = NIN - 1; k >= 0; k--) begin
        if (head_dir[rr_pick(rr_ptr[o], k)] == out_dir(o)) begin
          gnt_any[o] = 1'b1;
          gnt_idx[o] = rr_pick(rr_ptr[o], k);
        end
      end
    end
    for (int o = 0; o < 3; o++) begin
      if (can_load[o] && gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q <= 1'b1;
      for (int o = 0; o < 3; o++) begin
        out_q[o]  <= '0;
        rr_ptr[o] <= 2'd0;
      end
    end else begin
      rst_q <= 1'b0;
      for (int o = 0; o < 3; o++) begin
        if (can_load[o]) begin
          out_q[o] <= gnt_any[o] ? head[gnt_idx[o]] : '0;
          if (gnt_any[o]) rr_ptr[o] <= rr_pick(gnt_idx[o], 1);
        end
      end
    end
  end

  assign l_bus_o   = out_q[0];
  assign r_bus_o   = out_q[1];
  assign u_bus_o   = HAS_UP ? out_q[2] : '0;
  assign l_ready_o = rdy[0];
  assign r_ready_o = rdy[1];
  assign u_ready_o = rdy[2];

endmodule

// File: tb/tb_t_switch_buf.sv
// Directed bench for t_switch_buf: an inner switch (LEVEL=1) checked by a per-source/per-output
// scoreboard, plus a root switch (LEVEL=0) checked directly.
module tb_t_switch_buf;

  localparam int NL = 8;
  localparam int PS = 8;
  localparam int AW = 3;
  localparam int PW = 1 + AW + PS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [PW-1:0] bi [3];
  logic [2:0]    ri;
  logic [PW-1:0] l_bo, r_bo, u_bo;
  logic          l_ro, r_ro, u_ro;

  logic [PW-1:0] b0i [3];
  logic [2:0]    r0i;
  logic [PW-1:0] l0_bo, r0_bo, u0_bo;
  logic          l0_ro, r0_ro, u0_ro;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_q [9][$];
  int            u_log [$];

  t_switch_buf #(.NUM_LEAVES(NL), .PAYLOAD_SZ(PS), .LEVEL(1), .ADDR(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .l_bus_i(bi[0]), .r_bus_i(bi[1]), .u_bus_i(bi[2]),
    .l_ready_o(l_ro), .r_ready_o(r_ro), .u_ready_o(u_ro),
    .l_bus_o(l_bo), .r_bus_o(r_bo), .u_bus_o(u_bo),
    .l_ready_i(ri[0]), .r_ready_i(ri[1]), .u_ready_i(ri[2])
  );

  t_switch_buf #(.NUM_LEAVES(NL), .PAYLOAD_SZ(PS), .LEVEL(0), .ADDR(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset),
    .l_bus_i(b0i[0]), .r_bus_i(b0i[1]), .u_bus_i(b0i[2]),
    .l_ready_o(l0_ro), .r_ready_o(r0_ro), .u_ready_o(u0_ro),
    .l_bus_o(l0_bo), .r_bus_o(r0_bo), .u_bus_o(u0_bo),
    .l_ready_i(r0i[0]), .r_ready_i(r0i[1]), .u_ready_i(r0i[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Packet: {valid, dest, src[1:0], seq[5:0]}
  function automatic logic [PW-1:0] mk(input int src, input logic [2:0] dest, input int seq);
    return {1'b1, dest, 2'(src), 6'(seq)};
  endfunction

  // LEVEL=1, ADDR=0: dest[2]=0 stays in this subtree and dest[1] picks the side.
  function automatic int route_model(input logic [2:0] d);
    if (d[2]) return 2;
    return d[1] ? 1 : 0;
  endfunction

  task automatic push_exp(input int src, input logic [PW-1:0] p);
    logic [2:0] d;
    d = p[PW-2:PS];
    exp_q[src*3 + route_model(d)].push_back(p);
  endtask

  function automatic logic [PW-1:0] out_bus(input int o);
    case (o)
      0:       return l_bo;
      1:       return r_bo;
      default: return u_bo;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int o = 0; o < 3; o++) begin
      logic [PW-1:0] b;
      int            s;
      int            qi;
      b = out_bus(o);
      if (b[PW-1] && ri[o] && !reset) begin
        s  = int'(b[PS-1:PS-2]);
        qi = s * 3 + o;
        check("sb_expected_pending", 32'(exp_q[qi].size() != 0), 32'd1);
        if (exp_q[qi].size() != 0) check("sb_deliver", 32'(b), 32'(exp_q[qi].pop_front()));
        if (o == 2) u_log.push_back(s);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] p, held;
    bit            acc;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bi[i]  = '0;
      b0i[i] = '0;
    end
    ri  = 3'b111;
    r0i = 3'b111;

    // Reset state and release
    step(); step();
    @(negedge clk);
    check("rst_l_bus", 32'(l_bo), 0);
    check("rst_r_bus", 32'(r_bo), 0);
    check("rst_u_bus", 32'(u_bo), 0);
    check("rst_l_ready", 32'(l_ro), 0);
    check("rst_r_ready", 32'(r_ro), 0);
    check("rst_u_ready", 32'(u_ro), 0);
    reset = 1'b0;
    step();
    @(negedge clk);
    check("rel_l_ready", 32'(l_ro), 1);
    check("rel_r_ready", 32'(r_ro), 1);
    check("rel_u_ready", 32'(u_ro), 1);
    check("rel_root_l_ready", 32'(l0_ro), 1);
    check("rel_root_u_ready", 32'(u0_ro), 0);

    // Minimum latency U -> R
    step();
    p = mk(2, 3'b010, 1);
    bi[2] = p;
    push_exp(2, p);
    step();
    bi[2] = '0;
    @(negedge clk);
    check("lat_not_early", 32'(r_bo), 0);
    step();
    @(negedge clk);
    check("lat_two_cycles", 32'(r_bo), 32'(p));

    // L -> U, then L -> L turnback
    step();
    p = mk(0, 3'b100, 2);
    bi[0] = p;
    push_exp(0, p);
    step();
    held = mk(0, 3'b001, 3);
    bi[0] = held;
    push_exp(0, held);
    step();
    bi[0] = '0;
    @(negedge clk);
    check("route_up", 32'(u_bo), 32'(p));
    step();
    @(negedge clk);
    check("turnback_l", 32'(l_bo), 32'(held));
    repeat (6) step();

    // Contention on U from L and R
    u_log.delete();
    for (int k = 0; k < 4; k++) begin
      check("cont_l_ready", 32'(l_ro), 1);
      check("cont_r_ready", 32'(r_ro), 1);
      bi[0] = mk(0, 3'b100, 16 + k);
      bi[1] = mk(1, 3'b100, 16 + k);
      push_exp(0, bi[0]);
      push_exp(1, bi[1]);
      step();
    end
    bi[0] = '0;
    bi[1] = '0;
    repeat (12) step();
    check("cont_count", 32'(u_log.size()), 8);
    for (int k = 1; k < u_log.size(); k++)
      check("cont_alternate", 32'(u_log[k] != u_log[k-1]), 1);

    // Backpressure on U
    ri[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready_before_full", 32'(l_ro), 1);
      bi[0] = mk(0, 3'b100, 32 + k);
      push_exp(0, bi[0]);
      step();
    end
    p = mk(0, 3'b100, 37);
    bi[0] = p;
    check("bp_ready_full", 32'(l_ro), 0);
    check("bp_head", 32'(u_bo), 32'(mk(0, 3'b100, 32)));
    held = u_bo;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", 32'(u_bo), 32'(held));
      check("bp_ready_stays_low", 32'(l_ro), 0);
    end
    ri[2] = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (l_ro) begin
        push_exp(0, p);
        acc = 1'b1;
      end
      step();
    end
    bi[0] = '0;
    check("bp_sixth_accepted", 32'(acc), 1);
    repeat (12) step();

    // Reset with packets in flight
    ri[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mid_ready", 32'(l_ro), 1);
      bi[0] = mk(0, 3'b010, 48 + k);
      step();
    end
    bi[0] = '0;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_l_bus", 32'(l_bo), 0);
    check("mid_rst_r_bus", 32'(r_bo), 0);
    check("mid_rst_u_bus", 32'(u_bo), 0);
    check("mid_rst_l_ready", 32'(l_ro), 0);
    reset = 1'b0;
    ri[1] = 1'b1;
    step();
    @(negedge clk);
    check("mid_rel_l_ready", 32'(l_ro), 1);
    check("mid_rel_r_ready", 32'(r_ro), 1);
    check("mid_rel_u_ready", 32'(u_ro), 1);
    repeat (6) step();
    check("mid_flushed_r", 32'(r_bo), 0);

    // Root switch: dest 111 from L goes right; the U input is ignored
    b0i[0] = {1'b1, 3'b111, 8'h5C};
    b0i[2] = {1'b1, 3'b000, 8'hAA};
    check("root_u_ready_a", 32'(u0_ro), 0);
    step();
    b0i[0] = '0;
    @(negedge clk);
    check("root_not_early", 32'(r0_bo), 0);
    check("root_u_ready_b", 32'(u0_ro), 0);
    step();
    @(negedge clk);
    check("root_r_bus", 32'(r0_bo), 32'({1'b1, 3'b111, 8'h5C}));
    check("root_u_bus", 32'(u0_bo), 0);
    repeat (4) step();
    check("root_u_ignored", 32'(l0_bo), 0);
    check("root_u_ready_c", 32'(u0_ro), 0);
    b0i[2] = '0;

    for (int qi = 0; qi < 9; qi++) check("sb_queue_drained", 32'(exp_q[qi].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/t_switch_buf.md
T_SWITCH_BUF -- requirements
Module: t_switch_buf

Interface
REQ-001 SHALL have parameter NUM_LEAVES, default 256: number of leaves in the tree; a power of 2, at least 4.
REQ-002 SHALL have parameter PAYLOAD_SZ, default 43: payload width.
REQ-003 SHALL have parameter LEVEL, default 7: tree level of this switch; 0 = root, which has no up port.
REQ-004 SHALL have parameter ADDR, default 0: subtree prefix, LEVEL bits wide; ignored when LEVEL=0.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: per-input FIFO depth; a power of 2, at least 2.
REQ-006 SHALL have localparam AW = clog2(NUM_LEAVES) and localparam P_SZ = 1+AW+PAYLOAD_SZ; bus layout is {valid[P_SZ-1], dest[P_SZ-2:PAYLOAD_SZ], payload}.
REQ-007 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-high.
REQ-009 SHALL have ports l_bus_i, r_bus_i, u_bus_i  in  P_SZ  inbound packets.
REQ-010 SHALL have ports l_ready_o, r_ready_o, u_ready_o  out  1  inbound ready.
REQ-011 SHALL have ports l_bus_o, r_bus_o, u_bus_o  out  P_SZ  outbound packets.
REQ-012 SHALL have ports l_ready_i, r_ready_i, u_ready_i  in  1  outbound ready from the downstream stage.

Function
REQ-013 SHALL accept an input packet at a rising edge when its valid bit=1 and the matching x_ready_o=1; the packet is written into that port's FIFO.
REQ-014 SHALL drive x_ready_o = NOT full of FIFO x, from registered state only; there is no combinational path from any input to any ready_o.
REQ-015 SHALL route each FIFO head as follows.
  - LEVEL=0: dest[AW-1]=0 goes LEFT, =1 goes RIGHT.
  - LEVEL>0: if dest[AW-1:AW-LEVEL]==ADDR, dest[AW-1-LEVEL] selects LEFT (0) or RIGHT (1); otherwise the head goes UP.
REQ-016 SHALL permit turnback, i.e. a head routed out through its own arrival port (for example L to L).
REQ-017 SHALL give each output one register stage. Load rules:
  - The stage loads when it is empty or its bus valid=1 with ready_i=1 (drain and refill in the same edge).
  - When no packet is granted, the stage goes to all-zeros at the drain edge.
REQ-018 SHALL hold an output packet stable while its valid=1 and ready_i=0.
REQ-019 SHALL arbitrate each output by round-robin among the FIFO heads requesting it.
  - Order is L, R, U.
  - The per-output pointer moves to the input just after the winner, only on a grant.
REQ-020 SHALL pop a FIFO head only at the edge its grant loads an output stage; a losing head stays in place and is re-arbitrated next cycle.
REQ-021 SHALL have minimum latency 2 cycles: accepted at edge N, valid on bus_o after edge N+1, given an empty FIFO, a free output and no contention.
REQ-022 SHALL sustain 1 packet/cycle per output under continuous ready_i=1.
REQ-023 SHALL, when LEVEL=0, hold u_ready_o=0 and u_bus_o=0, ignore u_bus_i and u_ready_i, and use only LEFT/RIGHT arbitration.
REQ-024 SHALL, for a FIFO both written and popped at the same edge, keep its count unchanged; a full FIFO accepts no write because ready_o=0.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with full/empty derived from an (log2 FIFO_DEPTH + 1)-bit count.
REQ-026 SHALL never drop or duplicate a packet, and SHALL preserve per-input-to-output order.

Reset
REQ-027 SHALL, on reset=1 at an edge:
  - empty all FIFOs;
  - clear l_bus_o, r_bus_o and u_bus_o to 0;
  - set all RR pointers to L;
  - flush in-flight packets, which are discarded.
REQ-028 SHALL hold all ready_o=0 while reset=1, and in the first cycle after deassertion drive ready_o=1 (u_ready_o stays 0 when LEVEL=0).

Structure
REQ-029 SHALL take the direction encodings VOID/LEFT/RIGHT/UP (2 bits) and the bus field-slicing helper from a shared package bft_pkg.
REQ-030 SHALL instantiate a sub-module bft_fifo (synchronous, parameterised width and depth, with full, empty and count) once per input.

Verification
REQ-031 SHALL cover, with NUM_LEAVES=8, LEVEL=1, ADDR=0, FIFO_DEPTH=4, all ready_i=1: u_bus_i dest=3'b010 -> appears on r_bus_o exactly 2 cycles later with identical payload.
REQ-032 SHALL cover: l_bus_i dest=3'b100 -> routed to u_bus_o; l_bus_i dest=3'b001 -> turnback on l_bus_o.
REQ-033 SHALL cover contention: L and R heads both dest=3'b100 every cycle -> u_bus_o alternates L,R,L,R with no loss; both ready_o stay 1.
REQ-034 SHALL cover backpressure: u_ready_i=0 for 10 cycles, 6 packets to UP on l_bus_i -> l_ready_o falls after the 5th accept (4 in FIFO plus 1 in the output stage), and u_bus_o is held stable. On release, all 6 are delivered in order.
REQ-035 SHALL cover reset mid-traffic: reset asserted with 3 packets queued -> the next cycle shows all bus_o=0 and all FIFOs empty; ready_o=1 the cycle after deassertion.
REQ-036 SHALL cover LEVEL=0, NUM_LEAVES=8: dest=3'b111 from L -> r_bus_o; u_ready_o=0 throughout.
